// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM style requester bus between one master and the on-chip memory arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic              waitrequest;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port 32-bit on-chip memory.
// One memory transaction per clock. A read tag routes the returned data back to the
// requester that issued the read. Accesses at or above DEPTH never reach the memory.
// The first such access is latched in a sticky error register.
module onchip_mem_arbiter #(
    parameter int          ADDR_W   = 14,
    parameter int          DEPTH    = 10240,
    parameter logic [31:0] OOR_DATA = 32'hDEADBEEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                freeze,
    onchip_mem_arbiter_if.slave m0,
    onchip_mem_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [3:0]          mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [31:0]         mem_writedata,
    output logic                mem_clken,
    input  logic [31:0]         mem_readdata,
    output logic                err_valid,
    output logic                err_master,
    output logic [ADDR_W-1:0]   err_address,
    input  logic                err_clear
);

    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W+1)'(DEPTH);

    // True when a word address lies beyond the populated part of the memory.
    function automatic logic is_out_of_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} >= DEPTH_LIMIT);
    endfunction

    logic              req0_s;
    logic              req1_s;
    logic              grant_valid_s;
    logic              grant_id_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [3:0]        sel_be_s;
    logic              sel_read_s;
    logic              sel_write_s;
    logic [31:0]       sel_wdata_s;
    logic              sel_oor_s;
    logic              trap_s;
    logic              rd_valid_s;
    logic [31:0]       rd_data_s;

    logic              last_grant_r;
    logic              tag_valid_r;
    logic              tag_master_r;
    logic              tag_oor_r;
    logic              err_valid_r;
    logic              err_master_r;
    logic [ADDR_W-1:0] err_address_r;

    // Round-robin grant decision; reset and freeze block every grant.
    always_comb begin
        req0_s        = m0.read | m0.write;
        req1_s        = m1.read | m1.write;
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (reset || freeze) begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end else if (req0_s && req1_s) begin
            grant_valid_s = 1'b1;
            grant_id_s    = ~last_grant_r;
        end else if (req1_s) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b1;
        end else if (req0_s) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b0;
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // Select the granted master's request fields and classify the address.
    always_comb begin
        sel_addr_s  = m0.address;
        sel_be_s    = m0.byteenable;
        sel_read_s  = m0.read;
        sel_write_s = m0.write;
        sel_wdata_s = m0.writedata;
        if (grant_id_s) begin
            sel_addr_s  = m1.address;
            sel_be_s    = m1.byteenable;
            sel_read_s  = m1.read;
            sel_write_s = m1.write;
            sel_wdata_s = m1.writedata;
        end else begin
            sel_addr_s  = m0.address;
            sel_be_s    = m0.byteenable;
            sel_read_s  = m0.read;
            sel_write_s = m0.write;
            sel_wdata_s = m0.writedata;
        end
        sel_oor_s = is_out_of_range(sel_addr_s);
        trap_s    = grant_valid_s & sel_oor_s;
    end

    // Drive the memory port for in-range grants only; idle and trapped cycles stay quiet.
    always_comb begin
        mem_clken      = 1'b1;
        mem_address    = {ADDR_W{1'b0}};
        mem_byteenable = 4'b0000;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = 32'h0000_0000;
        if (grant_valid_s && !sel_oor_s) begin
            mem_address    = sel_addr_s;
            mem_byteenable = sel_be_s;
            mem_chipselect = 1'b1;
            mem_write      = sel_write_s;
            mem_writedata  = sel_wdata_s;
        end else begin
            mem_address    = {ADDR_W{1'b0}};
            mem_byteenable = 4'b0000;
            mem_chipselect = 1'b0;
            mem_write      = 1'b0;
            mem_writedata  = 32'h0000_0000;
        end
    end

    // Only the granted master is released from waitrequest.
    always_comb begin
        m0.waitrequest = ~(grant_valid_s & ~grant_id_s);
        m1.waitrequest = ~(grant_valid_s & grant_id_s);
    end

    // Return path: a reset in the data cycle swallows the pending strobe.
    always_comb begin
        rd_valid_s = tag_valid_r & ~reset;
        rd_data_s  = tag_oor_r ? OOR_DATA : mem_readdata;
        if (tag_master_r) begin
            m0.readdata      = mem_readdata;
            m0.readdatavalid = 1'b0;
            m1.readdata      = rd_data_s;
            m1.readdatavalid = rd_valid_s;
        end else begin
            m0.readdata      = rd_data_s;
            m0.readdatavalid = rd_valid_s;
            m1.readdata      = mem_readdata;
            m1.readdatavalid = 1'b0;
        end
    end

    // Remember the last winner so the other master wins the next contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= 1'b1;
        end else if (grant_valid_s) begin
            last_grant_r <= grant_id_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Read tag reloads every cycle. It is valid only for a read that was granted.
    // A simultaneous write wins, so read|write sets no tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid_r  <= 1'b0;
            tag_master_r <= 1'b0;
            tag_oor_r    <= 1'b0;
        end else begin
            tag_valid_r  <= grant_valid_s & sel_read_s & ~sel_write_s;
            tag_master_r <= grant_id_s;
            tag_oor_r    <= sel_oor_s;
        end
    end

    // Sticky trap record. A new trap overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid_r   <= 1'b0;
            err_master_r  <= 1'b0;
            err_address_r <= {ADDR_W{1'b0}};
        end else if (trap_s && (!err_valid_r || err_clear)) begin
            err_valid_r   <= 1'b1;
            err_master_r  <= grant_id_s;
            err_address_r <= sel_addr_s;
        end else if (err_clear) begin
            err_valid_r   <= 1'b0;
            err_master_r  <= err_master_r;
            err_address_r <= err_address_r;
        end else begin
            err_valid_r   <= err_valid_r;
            err_master_r  <= err_master_r;
            err_address_r <= err_address_r;
        end
    end

    assign err_valid   = err_valid_r;
    assign err_master  = err_master_r;
    assign err_address = err_address_r;

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-port round-robin arbiter that shares the single-port 32-bit on-chip memory (10240 words, 14-bit word address, one-cycle read latency) between two Avalon-MM style requesters, e.g. the Nios data master and a housekeeping DMA. It sits between the requesters and the memory's s1 port and issues at most one memory transaction per clock. It tags in-flight reads and returns read data to the correct requester. It also traps accesses above the populated depth and records them in a sticky error register.

## Interface
- `ADDR_W`, 14: word address width.
- `DEPTH`, 10240: number of populated words; addresses >= `DEPTH` are out of range.
- `OOR_DATA`, 32'hDEADBEEF: read data returned for out-of-range reads.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `freeze`  in  1  when high, no new grants are issued; an in-flight read still completes.
- `mN_address`  in  ADDR_W  requester N word address (N = 0, 1).
- `mN_byteenable`  in  4  requester N byte enables.
- `mN_read`  in  1  requester N read request.
- `mN_write`  in  1  requester N write request.
- `mN_writedata`  in  32  requester N write data.
- `mN_waitrequest`  out  1  high = request not accepted this cycle.
- `mN_readdata`  out  32  requester N read data.
- `mN_readdatavalid`  out  1  one-cycle strobe qualifying `mN_readdata`.
- `mem_address`  out  ADDR_W  to memory.
- `mem_byteenable`  out  4  to memory.
- `mem_chipselect`  out  1  to memory.
- `mem_write`  out  1  to memory.
- `mem_writedata`  out  32  to memory.
- `mem_clken`  out  1  tied high.
- `mem_readdata`  in  32  from memory; valid the cycle after the address is presented.
- `err_valid`  out  1  sticky out-of-range flag.
- `err_master`  out  1  requester ID of the first trapped access.
- `err_address`  out  ADDR_W  address of the first trapped access.
- `err_clear`  in  1  clears the error flag.

## Operation
- A request from master N is `mN_read | mN_write`. Asserting both `read` and `write` together is illegal; in that case `write` wins and no read tag is set.
- Arbitration is combinational and round-robin:
  - If only one master requests, that master is granted.
  - If both request, the master other than `last_grant` is granted.
  - `last_grant` updates to the granted master on every grant.
- On grant, `mN_waitrequest` for the granted master is 0 in the same cycle. Every other requesting master sees `waitrequest` = 1. When a master is not requesting, its `waitrequest` is 1.
- `freeze` = 1 or `reset` = 1 forces both `waitrequest` high. No memory access is issued in that state.
- In-range grant (address < `DEPTH`):
  - Drive `mem_*` from the granted master and set `mem_chipselect` = 1.
  - Set `mem_write` = the master's `write`.
- Out-of-range grant:
  - The request is accepted, but `mem_chipselect` = 0, so a write is discarded.
  - A read returns `OOR_DATA`.
  - If `err_valid` = 0, capture `err_master` and `err_address` and set `err_valid`.
  - Later trapped accesses do not overwrite the captured values.
- Read tag register: {valid, master, oor}, loaded on every cycle. It is valid only for a granted read.
  - Next cycle, if the tag is valid: assert `readdatavalid` for the tagged master.
  - `readdata` = `OOR_DATA` if oor, else `mem_readdata`.
- For the non-tagged master, `readdata` is `mem_readdata` (don't-care) and `readdatavalid` = 0.
- Error register: `err_clear` and a new trap in the same cycle leave the error set, holding the new trap's info. `err_clear` alone clears `err_valid`.
- When idle, `mem_chipselect` = 0 and `mem_write` = 0.

## Timing
- Reset values:
  - `last_grant` = 1, so master 0 wins the first contention.
  - Tag valid = 0.
  - `err_valid` = 0, `err_master` = 0, `err_address` = 0.
  - Both `readdatavalid` = 0.
  - Both `waitrequest` = 1 while `reset` is high.
- Write latency is 0: the write is accepted in the grant cycle and the memory writes at that clock edge.
- Read latency is 1: for a grant in cycle T, `readdatavalid` is high in T+1 only.
- Back-to-back reads give one per cycle; two contending masters each get 50 % throughput.
- Reset in cycle T+1 of an outstanding read: `readdatavalid` is suppressed in T+1. The tag clears at the edge.
- `freeze` asserted in cycle T+1 after a read grant in T: the read still completes in T+1, and no grant is made in T+1.

## Test plan
- Reset, then m0 reads address 5 holding 32'h12345678 → `m0_waitrequest` = 0 in cycle 0; `m0_readdatavalid` = 1 with 32'h12345678 in cycle 1; `m1_readdatavalid` stays 0.
- Both masters read continuously for 6 cycles → grants go m0, m1, m0, m1, m0, m1. Each master gets 3 `readdatavalid` pulses, each one cycle after its grant.
- m1 writes 32'hAABBCCDD to address 100 with `byteenable` = 4'b0011, then m0 reads address 100 (old value 0) → 32'h0000CCDD.
- m0 writes address 10240, then m1 reads address 12000 → write discarded with `mem_chipselect` = 0. m1 gets 32'hDEADBEEF. `err_valid` = 1 with `err_master` = 0 and `err_address` = 10240. Then `err_clear` → `err_valid` = 0.
- m0 read granted in T; `reset` high in T+1 → no `readdatavalid` in T+1. After reset, contention grants m0 first.
- `freeze` high for 3 cycles with both masters requesting → both `waitrequest` = 1 and `mem_chipselect` = 0. After release, arbitration resumes from the pre-freeze `last_grant`.
